// File: rtl/cbus_pkg.sv
// CBus request/response types shared by initiators and responders.
package cbus_pkg;

    typedef logic [3:0] mlen_t;  // beats - 1

    typedef enum logic {
        CbusIncr  = 1'b0,
        CbusFixed = 1'b1
    } cbus_burst_e;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        mlen_t       len;
        cbus_burst_e burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_mem_responder.sv
// CBus slave backed by a 64-bit word memory: fixed first-beat latency, INCR/FIXED bursts,
// byte strobes on writes. All outputs are registered.
module cbus_mem_responder
    import cbus_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq_i,
    output cbus_resp_t cresp_o,
    output logic       busy_o
);

    localparam int unsigned AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0]  LatLast = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StBeat,
        StTurn
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     wait_q, wait_d;
    mlen_t          beat_q, beat_d;
    mlen_t          len_q, len_d;
    cbus_burst_e    burst_q, burst_d;
    logic           wr_q, wr_d;
    logic           ok_q, ok_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic           ready_q, ready_d;
    logic           last_q, last_d;
    logic [63:0]    data_q, data_d;
    logic           busy_q, busy_d;

    logic [63:0]    mem [MEM_WORDS];

    logic [63:0]    offset;
    logic [63:0]    word;
    logic           in_range;
    logic           unused_size;

    assign offset      = creq_i.addr - BASE_ADDR;
    assign word        = offset >> 3;
    assign in_range    = (creq_i.addr >= BASE_ADDR) && (word < 64'(MEM_WORDS));
    assign unused_size = ^creq_i.size;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        len_d   = len_q;
        burst_d = burst_q;
        wr_d    = wr_q;
        ok_d    = ok_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (creq_i.valid) begin
                    len_d   = creq_i.len;
                    burst_d = creq_i.burst;
                    wr_d    = creq_i.is_write;
                    ok_d    = in_range;
                    idx_d   = word[AW-1:0];
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = (LATENCY > 0) ? StWait : StBeat;
                end
            end
            StWait: begin
                if (wait_q == LatLast) begin
                    state_d = StBeat;
                end else begin
                    wait_d = 4'(wait_q + 4'd1);
                end
            end
            StBeat: begin
                if (beat_q == len_q) begin
                    state_d = StTurn;
                end else begin
                    beat_d = 4'(beat_q + 4'd1);
                    if (burst_q == CbusIncr) begin
                        idx_d = AW'(idx_q + 1);  // wraps modulo MEM_WORDS
                    end
                end
            end
            StTurn: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output registers are loaded with what the next cycle presents, so data is read early.
    always_comb begin
        ready_d = (state_d == StBeat);
        last_d  = ready_d && (beat_d == len_d);
        busy_d  = (state_d != StIdle);
        data_d  = '0;
        if (ready_d && !wr_d && ok_d) begin
            data_d = mem[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            wait_q  <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            burst_q <= CbusIncr;
            wr_q    <= 1'b0;
            ok_q    <= 1'b0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            wr_q    <= wr_d;
            ok_q    <= ok_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            last_q  <= last_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    // Memory has no reset; a write beat commits at the end of its ready cycle.
    always_ff @(posedge clk) begin
        if (reset && (state_q == StBeat) && wr_q && ok_q) begin
            for (int b = 0; b < 8; b++) begin
                if (creq_i.strobe[b]) begin
                    mem[idx_q][8*b +: 8] <= creq_i.data[8*b +: 8];
                end
            end
        end
    end

    assign cresp_o.ready = ready_q;
    assign cresp_o.last  = last_q;
    assign cresp_o.data  = data_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed plus random bursts against a word-array reference model of the responder memory.
module tb_cbus_mem_responder;
    import cbus_pkg::*;

    localparam int unsigned MW   = 1024;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int unsigned LAT  = 2;

    logic       clk;
    logic       reset;
    cbus_req_t  creq;
    cbus_resp_t cresp;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [63:0] model [MW];
    logic [63:0] wbuf [16];
    logic [7:0]  sbuf [16];
    logic [63:0] rd_first;

    cbus_mem_responder #(
        .MEM_WORDS(MW),
        .BASE_ADDR(BASE),
        .LATENCY  (LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .creq_i (creq),
        .cresp_o(cresp),
        .busy_o (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_ok(input logic [63:0] a);
        return (a >= BASE) && (((a - BASE) >> 3) < 64'(MW));
    endfunction

    function automatic int unsigned word_at(input logic [63:0] a, input int unsigned k,
                                            input logic fixed);
        logic [63:0] w;
        w = (a - BASE) >> 3;
        if (!fixed) w = (w + 64'(k)) % 64'(MW);
        return int'(w[31:0]);
    endfunction

    task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [3:0] len,
                           input logic fixed, input logic drop);
        int          n;
        int          c;
        int unsigned idx;
        logic        inr;
        logic [63:0] exp;
        n   = int'(len) + 1;
        inr = addr_ok(addr);
        creq.valid    = 1'b1;
        creq.is_write = wr;
        creq.size     = 3'd3;
        creq.addr     = addr;
        creq.len      = len;
        creq.burst    = fixed ? CbusFixed : CbusIncr;
        creq.data     = wbuf[0];
        creq.strobe   = sbuf[0];
        @(posedge clk); #1;
        if (drop) creq.valid = 1'b0;
        check("busy_after_capture", 64'(busy), 64'd1);
        check("data_idle_wait", cresp.data, 64'd0);
        c = 0;
        while (!cresp.ready && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        check("first_beat_latency", 64'(c), 64'(LAT));
        if (!cresp.ready) begin
            creq.valid = 1'b0;
            return;
        end
        for (int k = 0; k < n; k++) begin
            idx = inr ? word_at(addr, k, fixed) : 0;
            exp = (!wr && inr) ? model[idx] : 64'd0;
            if (k == 0) rd_first = cresp.data;
            check("beat_ready", 64'(cresp.ready), 64'd1);
            check("beat_last", 64'(cresp.last), 64'(k == n - 1));
            check("beat_data", cresp.data, exp);
            if (wr) begin
                creq.data   = wbuf[k];
                creq.strobe = sbuf[k];
            end
            @(posedge clk); #1;
            if (wr && inr) begin
                for (int b = 0; b < 8; b++) begin
                    if (sbuf[k][b]) model[idx][8*b +: 8] = wbuf[k][8*b +: 8];
                end
            end
        end
        // Turnaround cycle: valid may still be high and must not be captured.
        check("turn_ready", 64'(cresp.ready), 64'd0);
        check("turn_last", 64'(cresp.last), 64'd0);
        check("turn_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("idle_busy", 64'(busy), 64'd0);
        creq.valid = 1'b0;
    endtask

    initial begin
        int c;
        logic [63:0] a;
        reset = 1'b0;
        creq  = '0;
        creq.valid    = 1'b1;
        creq.is_write = 1'b1;
        creq.addr     = BASE;
        creq.strobe   = 8'hFF;
        creq.data     = 64'hAAAA_AAAA_AAAA_AAAA;
        repeat (3) @(posedge clk);
        #1;
        check("por_ready", 64'(cresp.ready), 64'd0);
        check("por_last", 64'(cresp.last), 64'd0);
        check("por_busy", 64'(busy), 64'd0);
        check("por_data", cresp.data, 64'd0);
        creq.valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        // Fill the whole memory with known content.
        for (int i = 0; i < int'(MW / 16); i++) begin
            for (int k = 0; k < 16; k++) begin
                wbuf[k] = {$urandom, $urandom};
                sbuf[k] = 8'hFF;
            end
            run_txn(1'b1, BASE + 64'(i * 128), 4'd15, 1'b0, 1'b0);
        end

        // Reset held with a write request pending writes nothing.
        creq.valid = 1'b1; creq.is_write = 1'b1; creq.addr = BASE; creq.len = 4'd0;
        creq.burst = CbusIncr; creq.strobe = 8'hFF; creq.data = 64'h5555_5555_5555_5555;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(cresp.ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        creq.valid = 1'b0;
        @(posedge clk); #1;
        run_txn(1'b0, BASE, 4'd0, 1'b0, 1'b0);

        // Single-beat read of a known word.
        wbuf[0] = 64'hDEAD_BEEF_0123_4567; sbuf[0] = 8'hFF;
        run_txn(1'b1, BASE, 4'd0, 1'b0, 1'b0);
        run_txn(1'b0, BASE, 4'd0, 1'b0, 1'b0);
        check("single_read_value", rd_first, 64'hDEAD_BEEF_0123_4567);

        // INCR write 1..4 then read back.
        for (int k = 0; k < 4; k++) begin
            wbuf[k] = 64'(k + 1);
            sbuf[k] = 8'hFF;
        end
        run_txn(1'b1, BASE + 64'd8, 4'd3, 1'b0, 1'b0);
        run_txn(1'b0, BASE + 64'd8, 4'd3, 1'b0, 1'b0);
        check("incr_first_value", rd_first, 64'd1);

        // Byte strobes merge into an existing word.
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'hFF;
        run_txn(1'b1, BASE + 64'd40, 4'd0, 1'b0, 1'b0);
        wbuf[0] = 64'd0; sbuf[0] = 8'h0F;
        run_txn(1'b1, BASE + 64'd40, 4'd0, 1'b0, 1'b0);
        run_txn(1'b0, BASE + 64'd40, 4'd0, 1'b0, 1'b0);
        check("strobe_merge", rd_first, 64'hFFFF_FFFF_0000_0000);

        // FIXED read and INCR wrap from the last word.
        run_txn(1'b0, BASE + 64'd16, 4'd3, 1'b1, 1'b0);
        run_txn(1'b0, BASE + 64'(8 * (MW - 1)), 4'd1, 1'b0, 1'b0);

        // Out-of-range read returns zero; out-of-range writes are dropped.
        run_txn(1'b0, BASE - 64'd8, 4'd0, 1'b0, 1'b0);
        check("oob_read_zero", rd_first, 64'd0);
        wbuf[0] = 64'h1234_5678_9ABC_DEF0; sbuf[0] = 8'hFF;
        run_txn(1'b1, BASE - 64'd8, 4'd0, 1'b0, 1'b0);
        run_txn(1'b1, BASE + 64'(8 * MW), 4'd0, 1'b0, 1'b0);
        run_txn(1'b0, BASE, 4'd0, 1'b0, 1'b0);
        run_txn(1'b0, BASE + 64'(8 * (MW - 1)), 4'd0, 1'b0, 1'b0);

        // Initiator drops valid early: burst still completes.
        run_txn(1'b0, BASE + 64'd64, 4'd3, 1'b0, 1'b1);

        // Reset during the second beat of an 8-beat read aborts it.
        creq.valid = 1'b1; creq.is_write = 1'b0; creq.addr = BASE + 64'd256;
        creq.len = 4'd7; creq.burst = CbusIncr;
        @(posedge clk); #1;
        c = 0;
        while (!cresp.ready && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        check("abort_first_beat", 64'(cresp.ready), 64'd1);
        @(posedge clk); #1;
        check("abort_second_beat", 64'(cresp.ready), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_ready", 64'(cresp.ready), 64'd0);
        check("abort_last", 64'(cresp.last), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_data", cresp.data, 64'd0);
        reset = 1'b1;
        creq.valid = 1'b0;
        @(posedge clk); #1;
        check("abort_stays_idle", 64'(busy), 64'd0);
        run_txn(1'b0, BASE + 64'd256, 4'd2, 1'b0, 1'b0);

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            c = int'($urandom_range(0, 9));
            if (c == 0) a = BASE - 64'(8 * $urandom_range(1, 4));
            else if (c == 1) a = BASE + 64'(8 * MW) + 64'(8 * $urandom_range(0, 100));
            else a = BASE + 64'(8 * $urandom_range(0, MW - 1)) + 64'($urandom_range(0, 7));
            for (int k = 0; k < 16; k++) begin
                wbuf[k] = {$urandom, $urandom};
                sbuf[k] = 8'($urandom);
            end
            run_txn(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
